cache_refill_arbiter: RTL and testbench

//  Shares one AXI3 read port between the I-cache and D-cache line-refill engines.

---
 rtl/refill_pkg.sv | 11 +
 rtl/cache_refill_arbiter_if.sv | 26 ++
 rtl/rr_arb2.sv | 22 ++
 rtl/cache_refill_arbiter.sv | 116 +++++++++++
 tb/tb_cache_refill_arbiter.sv | 265 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/refill_pkg.sv
// rtl/refill_pkg.sv - shared types and constants for the cache refill arbiter
package refill_pkg;
    localparam int DEF_OFFSET_LEN = 5;
    localparam int LINE_WORDS     = 1 << (DEF_OFFSET_LEN - 2);

    localparam logic [2:0] ARSIZE_WORD  = 3'b010;
    localparam logic [1:0] ARBURST_INCR = 2'b01;

    typedef enum logic [1:0] {IDLE, AR, R, DONE} state_t;
    typedef enum logic       {OWN_I, OWN_D}      owner_t;
endpackage

// File: rtl/cache_refill_arbiter_if.sv
// rtl/cache_refill_arbiter_if.sv - AXI3 read address/data channels shared by both refill engines
interface cache_refill_arbiter_if;
    logic [3:0]  arid;
    logic [31:0] araddr;
    logic [3:0]  arlen;
    logic [2:0]  arsize;
    logic [1:0]  arburst;
    logic        arvalid;
    logic        arready;
    logic [3:0]  rid;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rlast;
    logic        rvalid;
    logic        rready;

    modport master (
        output arid, araddr, arlen, arsize, arburst, arvalid, rready,
        input  arready, rid, rdata, rresp, rlast, rvalid
    );

    modport slave (
        input  arid, araddr, arlen, arsize, arburst, arvalid, rready,
        output arready, rid, rdata, rresp, rlast, rvalid
    );
endinterface

// File: rtl/rr_arb2.sv
// rtl/rr_arb2.sv - two-way round-robin picker; the last-owner pointer lives in the parent
module rr_arb2
    import refill_pkg::*;
(
    input  logic [1:0] req,
    input  owner_t     last,
    input  logic       en,
    output owner_t     pick,
    output logic       valid
);
    // req[0] is the I-cache, req[1] the D-cache; a tie goes to whoever did not win last
    always_comb begin
        pick = OWN_I;
        if (req == 2'b10) begin
            pick = OWN_D;
        end else if (req == 2'b11) begin
            pick = (last == OWN_I) ? OWN_D : OWN_I;
        end
    end

    assign valid = en & (|req);
endmodule

// File: rtl/cache_refill_arbiter.sv
// rtl/cache_refill_arbiter.sv - shares one AXI3 read port between I- and D-cache line refills
module cache_refill_arbiter
    import refill_pkg::*;
#(
    parameter int         OFFSET_LEN = DEF_OFFSET_LEN,
    parameter logic [3:0] ID_I       = 4'd0,
    parameter logic [3:0] ID_D       = 4'd1
) (
    input  logic                          clk,
    input  logic                          resetn,
    input  logic                          i_req,
    input  logic [31:0]                   i_addr,
    output logic                          i_gnt,
    input  logic                          d_req,
    input  logic [31:0]                   d_addr,
    output logic                          d_gnt,
    output logic [(1 << (OFFSET_LEN-2))-1:0][31:0] line_data,
    cache_refill_arbiter_if.master        axi
);
    localparam int          LW        = 1 << (OFFSET_LEN - 2);
    localparam int          BW        = OFFSET_LEN - 2;
    localparam logic [31:0] ADDR_MASK = ~((32'd1 << OFFSET_LEN) - 32'd1);

    state_t                r_state;
    owner_t                r_owner;
    owner_t                r_last;
    logic                  r_arvalid;
    logic                  r_rready;
    logic                  r_i_gnt;
    logic                  r_d_gnt;
    logic [BW-1:0]         r_beat;
    logic [31:0]           r_araddr;
    logic [3:0]            r_arid;
    logic [LW-1:0][31:0]   r_line;

    owner_t                w_pick;
    logic                  w_valid;
    logic [31:0]           w_sel_addr;

    rr_arb2 u_arb (
        .req   ({d_req, i_req}),
        .last  (r_last),
        .en    (r_state == IDLE),
        .pick  (w_pick),
        .valid (w_valid)
    );

    assign w_sel_addr = (w_pick == OWN_I) ? i_addr : d_addr;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state   <= IDLE;
            r_owner   <= OWN_I;
            r_last    <= OWN_D;
            r_arvalid <= 1'b0;
            r_rready  <= 1'b0;
            r_i_gnt   <= 1'b0;
            r_d_gnt   <= 1'b0;
            r_beat    <= '0;
            r_araddr  <= '0;
            r_arid    <= '0;
            r_line    <= '0;
        end else begin
            r_i_gnt <= 1'b0;
            r_d_gnt <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_valid) begin
                        r_owner   <= w_pick;
                        r_araddr  <= w_sel_addr & ADDR_MASK;
                        r_arid    <= (w_pick == OWN_I) ? ID_I : ID_D;
                        r_arvalid <= 1'b1;
                        r_state   <= AR;
                    end
                end
                AR: begin
                    if (axi.arready) begin
                        r_arvalid <= 1'b0;
                        r_rready  <= 1'b1;
                        r_beat    <= '0;
                        r_state   <= R;
                    end
                end
                R: begin
                    // beat_cnt wraps, so an overlong burst overwrites from word 0
                    if (axi.rvalid) begin
                        r_line[r_beat] <= axi.rdata;
                        r_beat         <= r_beat + 1'b1;
                        if (axi.rlast) begin
                            r_rready <= 1'b0;
                            r_i_gnt  <= (r_owner == OWN_I);
                            r_d_gnt  <= (r_owner == OWN_D);
                            r_state  <= DONE;
                        end
                    end
                end
                DONE: begin
                    r_last  <= r_owner;
                    r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign axi.arid    = r_arid;
    assign axi.araddr  = r_araddr;
    assign axi.arlen   = 4'(LW - 1);
    assign axi.arsize  = ARSIZE_WORD;
    assign axi.arburst = ARBURST_INCR;
    assign axi.arvalid = r_arvalid;
    assign axi.rready  = r_rready;
    assign i_gnt       = r_i_gnt;
    assign d_gnt       = r_d_gnt;
    assign line_data   = r_line;
endmodule

// File: tb/tb_cache_refill_arbiter.sv
// tb/tb_cache_refill_arbiter.sv - directed self-checking bench for cache_refill_arbiter
module tb_cache_refill_arbiter;
    import refill_pkg::*;

    logic                        clk = 1'b0;
    logic                        resetn;
    logic                        i_req, d_req;
    logic [31:0]                 i_addr, d_addr;
    logic                        i_gnt, d_gnt;
    logic [LINE_WORDS-1:0][31:0] line_data;

    cache_refill_arbiter_if axi ();

    cache_refill_arbiter dut (
        .clk       (clk),
        .resetn    (resetn),
        .i_req     (i_req),
        .i_addr    (i_addr),
        .i_gnt     (i_gnt),
        .d_req     (d_req),
        .d_addr    (d_addr),
        .d_gnt     (d_gnt),
        .line_data (line_data),
        .axi       (axi)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    int i_gnt_cnt = 0, d_gnt_cnt = 0, dbl_cnt = 0, ovl_cnt = 0;

    always @(posedge clk) cyc++;

    always @(posedge clk) begin
        #2;
        if (i_gnt) i_gnt_cnt++;
        if (d_gnt) d_gnt_cnt++;
        if (i_gnt && d_gnt) dbl_cnt++;
        if (axi.arvalid && axi.rready) ovl_cnt++;
    end

    // AXI slave: accept AR after ar_delay cycles, then return nbeats beats of base+k
    task automatic serve(input int ar_delay, input bit gapped, input int nbeats,
                         input logic [31:0] base, output logic [31:0] addr_o,
                         output logic [3:0] id_o, output bit stable_o,
                         output int wait_o, output bit to_o);
        to_o = 1'b0; stable_o = 1'b1; wait_o = 0; addr_o = '0; id_o = '0;
        while (!axi.arvalid && wait_o < 50) begin
            @(negedge clk);
            wait_o++;
        end
        if (!axi.arvalid) begin
            to_o = 1'b1;
            return;
        end
        addr_o = axi.araddr;
        id_o   = axi.arid;
        repeat (ar_delay) begin
            @(negedge clk);
            if (!axi.arvalid || axi.araddr !== addr_o || axi.arid !== id_o || axi.rready)
                stable_o = 1'b0;
        end
        axi.arready = 1'b1;
        @(negedge clk);
        axi.arready = 1'b0;
        for (int k = 0; k < nbeats; k++) begin
            if (gapped) begin
                axi.rvalid = 1'b0;
                @(negedge clk);
            end
            if (!axi.rready) stable_o = 1'b0;
            axi.rvalid = 1'b1;
            axi.rdata  = base + 32'(k);
            axi.rlast  = (k == nbeats - 1);
            @(negedge clk);
        end
        axi.rvalid = 1'b0;
        axi.rlast  = 1'b0;
    endtask

    task automatic test_reset();
        n_tests++; if (axi.arvalid !== 1'b0) begin n_fail++; $display("FAIL reset_arvalid got %b want 0", axi.arvalid); end
        n_tests++; if (axi.rready !== 1'b0) begin n_fail++; $display("FAIL reset_rready got %b want 0", axi.rready); end
        n_tests++; if ({i_gnt, d_gnt} !== 2'b00) begin n_fail++; $display("FAIL reset_gnt got %b want 00", {i_gnt, d_gnt}); end
        n_tests++; if (line_data !== '0) begin n_fail++; $display("FAIL reset_line got %h want 0", line_data); end
        n_tests++; if (axi.arlen !== 4'd7) begin n_fail++; $display("FAIL arlen got %0d want 7", axi.arlen); end
        n_tests++; if (axi.arsize !== 3'b010) begin n_fail++; $display("FAIL arsize got %b want 010", axi.arsize); end
        n_tests++; if (axi.arburst !== 2'b01) begin n_fail++; $display("FAIL arburst got %b want 01", axi.arburst); end
    endtask

    task automatic test_single_i();
        logic [31:0] a; logic [3:0] id; bit st, to; int w, c0, g0;
        i_addr = 32'h1FC0_0024; i_req = 1'b1; c0 = cyc; g0 = i_gnt_cnt;
        serve(0, 1'b0, 8, 32'h0, a, id, st, w, to);
        n_tests++; if (to !== 1'b0) begin n_fail++; $display("FAIL t1_ar_timeout got %b want 0", to); end
        n_tests++; if (a !== 32'h1FC0_0020) begin n_fail++; $display("FAIL t1_araddr got %h want 1fc00020", a); end
        n_tests++; if (id !== 4'd0) begin n_fail++; $display("FAIL t1_arid got %0d want 0", id); end
        n_tests++; if (i_gnt !== 1'b1) begin n_fail++; $display("FAIL t1_i_gnt got %b want 1", i_gnt); end
        n_tests++; if (cyc - c0 !== 10) begin n_fail++; $display("FAIL t1_latency got %0d want 10 edges (gnt in cycle 11)", cyc - c0); end
        n_tests++; if (i_gnt_cnt - g0 !== 1) begin n_fail++; $display("FAIL t1_gnt_count got %0d want 1", i_gnt_cnt - g0); end
        for (int k = 0; k < 8; k++) begin
            n_tests++; if (line_data[k] !== 32'(k)) begin n_fail++; $display("FAIL t1_word%0d got %h want %h", k, line_data[k], k); end
        end
        i_req = 1'b0;
        @(negedge clk);
        n_tests++; if (i_gnt !== 1'b0) begin n_fail++; $display("FAIL t1_gnt_pulse got %b want 0", i_gnt); end
    endtask

    task automatic test_round_robin();
        logic [31:0] a; logic [3:0] id; bit st, to; int w;
        resetn = 1'b0; @(negedge clk); resetn = 1'b1;
        i_addr = 32'h0000_1000; d_addr = 32'h2000_0047; i_req = 1'b1; d_req = 1'b1;
        serve(0, 1'b0, 8, 32'h100, a, id, st, w, to);
        n_tests++; if (id !== 4'd0) begin n_fail++; $display("FAIL t2_first_id got %0d want 0", id); end
        n_tests++; if ({i_gnt, d_gnt} !== 2'b10) begin n_fail++; $display("FAIL t2_first_gnt got %b want 10", {i_gnt, d_gnt}); end
        i_req = 1'b0;
        @(negedge clk);
        n_tests++; if (axi.arvalid !== 1'b0) begin n_fail++; $display("FAIL t2_idle_gap got %b want 0", axi.arvalid); end
        serve(0, 1'b0, 8, 32'h200, a, id, st, w, to);
        n_tests++; if (w !== 1) begin n_fail++; $display("FAIL t2_d_start got %0d want 1", w); end
        n_tests++; if (id !== 4'd1) begin n_fail++; $display("FAIL t2_d_id got %0d want 1", id); end
        n_tests++; if (a !== 32'h2000_0040) begin n_fail++; $display("FAIL t2_d_addr got %h want 20000040", a); end
        n_tests++; if ({i_gnt, d_gnt} !== 2'b01) begin n_fail++; $display("FAIL t2_d_gnt got %b want 01", {i_gnt, d_gnt}); end
        n_tests++; if (line_data[5] !== 32'h205) begin n_fail++; $display("FAIL t2_d_word5 got %h want 205", line_data[5]); end
        d_req = 1'b0;
        @(negedge clk);
        i_req = 1'b1; d_req = 1'b1;
        serve(0, 1'b0, 8, 32'h280, a, id, st, w, to);
        n_tests++; if (id !== 4'd0) begin n_fail++; $display("FAIL t2_tie_after_d got %0d want 0", id); end
        i_req = 1'b0;
        @(negedge clk);
        serve(0, 1'b0, 8, 32'h2C0, a, id, st, w, to);
        n_tests++; if (id !== 4'd1) begin n_fail++; $display("FAIL t2_tie_after_i got %0d want 1", id); end
        d_req = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_stalls();
        logic [31:0] a; logic [3:0] id; bit st, to; int w, g0;
        i_addr = 32'h0000_3004; i_req = 1'b1; g0 = i_gnt_cnt;
        serve(5, 1'b1, 8, 32'h300, a, id, st, w, to);
        n_tests++; if (st !== 1'b1) begin n_fail++; $display("FAIL t3_ar_stable got %b want 1", st); end
        n_tests++; if (a !== 32'h0000_3000) begin n_fail++; $display("FAIL t3_araddr got %h want 3000", a); end
        n_tests++; if (i_gnt !== 1'b1 || i_gnt_cnt - g0 !== 1) begin n_fail++; $display("FAIL t3_gnt_after_rlast got gnt=%b cnt=%0d want 1/1", i_gnt, i_gnt_cnt - g0); end
        for (int k = 0; k < 8; k++) begin
            n_tests++; if (line_data[k] !== 32'h300 + 32'(k)) begin n_fail++; $display("FAIL t3_word%0d got %h want %h", k, line_data[k], 32'h300 + k); end
        end
        i_req = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_early_rlast();
        logic [31:0] a; logic [3:0] id; bit st, to; int w;
        d_addr = 32'h0000_4000; d_req = 1'b1;
        serve(0, 1'b0, 4, 32'h400, a, id, st, w, to);
        n_tests++; if (d_gnt !== 1'b1) begin n_fail++; $display("FAIL t4_gnt got %b want 1", d_gnt); end
        for (int k = 0; k < 8; k++) begin
            n_tests++;
            if (line_data[k] !== ((k < 4) ? 32'h400 + 32'(k) : 32'h300 + 32'(k))) begin
                n_fail++; $display("FAIL t4_word%0d got %h want %h", k, line_data[k], (k < 4) ? 32'h400 + k : 32'h300 + k);
            end
        end
        d_req = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_wrap();
        logic [31:0] a; logic [3:0] id; bit st, to; int w;
        i_addr = 32'h0000_5000; i_req = 1'b1;
        serve(0, 1'b0, 9, 32'h500, a, id, st, w, to);
        n_tests++; if (i_gnt !== 1'b1) begin n_fail++; $display("FAIL t_wrap_gnt got %b want 1", i_gnt); end
        n_tests++; if (line_data[0] !== 32'h508) begin n_fail++; $display("FAIL t_wrap_word0 got %h want 508", line_data[0]); end
        n_tests++; if (line_data[7] !== 32'h507) begin n_fail++; $display("FAIL t_wrap_word7 got %h want 507", line_data[7]); end
        i_req = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_rvalid_ignored();
        logic [31:0] a; logic [3:0] id; bit st, to; int w;
        axi.rvalid = 1'b1; axi.rdata = 32'hDEAD_0BAD;
        repeat (3) @(negedge clk);
        n_tests++; if (line_data[0] !== 32'h508 || line_data[1] !== 32'h501) begin n_fail++; $display("FAIL t_idle_rvalid got %h/%h want 508/501", line_data[0], line_data[1]); end
        n_tests++; if (axi.rready !== 1'b0) begin n_fail++; $display("FAIL t_idle_rready got %b want 0", axi.rready); end
        i_addr = 32'h0000_6000; i_req = 1'b1;
        serve(3, 1'b0, 8, 32'h600, a, id, st, w, to);
        n_tests++; if (st !== 1'b1) begin n_fail++; $display("FAIL t_ar_rready got %b want 1", st); end
        i_req = 1'b0; axi.rvalid = 1'b1; axi.rdata = 32'hDEAD_0BAD;
        repeat (2) @(negedge clk);
        axi.rvalid = 1'b0;
        for (int k = 0; k < 8; k++) begin
            n_tests++; if (line_data[k] !== 32'h600 + 32'(k)) begin n_fail++; $display("FAIL t_hold_word%0d got %h want %h", k, line_data[k], 32'h600 + k); end
        end
    endtask

    task automatic test_reset_mid_burst();
        logic [31:0] a; logic [3:0] id; bit st, to; int w;
        d_addr = 32'h0000_7000; d_req = 1'b1; w = 0;
        while (!axi.arvalid && w < 50) begin @(negedge clk); w++; end
        n_tests++; if (axi.arvalid !== 1'b1) begin n_fail++; $display("FAIL t5_ar_timeout got %b want 1", axi.arvalid); end
        axi.arready = 1'b1; @(negedge clk); axi.arready = 1'b0;
        for (int k = 0; k < 2; k++) begin
            axi.rvalid = 1'b1; axi.rdata = 32'h700 + 32'(k); @(negedge clk);
        end
        axi.rdata = 32'h7FF;
        resetn = 1'b0;
        #1;
        n_tests++; if ({axi.arvalid, axi.rready, i_gnt, d_gnt} !== 4'b0000) begin n_fail++; $display("FAIL t5_abort got %b want 0000", {axi.arvalid, axi.rready, i_gnt, d_gnt}); end
        n_tests++; if (dut.r_state !== IDLE) begin n_fail++; $display("FAIL t5_state got %0d want IDLE", dut.r_state); end
        n_tests++; if (line_data !== '0) begin n_fail++; $display("FAIL t5_line got %h want 0", line_data); end
        @(negedge clk); @(negedge clk);
        axi.rvalid = 1'b0; resetn = 1'b1;
        serve(0, 1'b0, 8, 32'h800, a, id, st, w, to);
        n_tests++; if (id !== 4'd1 || d_gnt !== 1'b1) begin n_fail++; $display("FAIL t5_resume got id=%0d gnt=%b want 1/1", id, d_gnt); end
        n_tests++; if (line_data[3] !== 32'h803) begin n_fail++; $display("FAIL t5_word3 got %h want 803", line_data[3]); end
        d_req = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        logic [31:0] a, a2; logic [3:0] id, id2; bit st, to, st2, to2; int w, w2;
        i_addr = 32'h0000_9000; d_addr = 32'h0000_A000; i_req = 1'b1;
        fork
            serve(0, 1'b1, 8, 32'h900, a, id, st, w, to);
            begin repeat (4) @(negedge clk); d_req = 1'b1; end
        join
        n_tests++; if ({i_gnt, d_gnt, axi.arvalid} !== 3'b100) begin n_fail++; $display("FAIL t6_i_done got %b want 100", {i_gnt, d_gnt, axi.arvalid}); end
        i_req = 1'b0;
        @(negedge clk);
        n_tests++; if (axi.arvalid !== 1'b0) begin n_fail++; $display("FAIL t6_no_early_ar got %b want 0", axi.arvalid); end
        serve(0, 1'b0, 8, 32'hA00, a2, id2, st2, w2, to2);
        n_tests++; if (w2 !== 1 || id2 !== 4'd1 || d_gnt !== 1'b1) begin n_fail++; $display("FAIL t6_d_follow got w=%0d id=%0d gnt=%b want 1/1/1", w2, id2, d_gnt); end
        d_req = 1'b0;
        @(negedge clk);
        n_tests++; if (dbl_cnt !== 0) begin n_fail++; $display("FAIL double_gnt got %0d want 0", dbl_cnt); end
        n_tests++; if (ovl_cnt !== 0) begin n_fail++; $display("FAIL arvalid_rready_overlap got %0d want 0", ovl_cnt); end
    endtask

    initial begin
        resetn = 1'b0; i_req = 1'b0; d_req = 1'b0; i_addr = '0; d_addr = '0;
        axi.arready = 1'b0; axi.rvalid = 1'b0; axi.rlast = 1'b0;
        axi.rdata = '0; axi.rid = '0; axi.rresp = '0;
        @(negedge clk); @(negedge clk);
        test_reset();
        resetn = 1'b1;
        @(negedge clk);
        test_single_i();
        test_round_robin();
        test_stalls();
        test_early_rlast();
        test_wrap();
        test_rvalid_ignored();
        test_reset_mid_burst();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog got timeout want completion");
        $fatal(1, "watchdog");
    end
endmodule
